// File: rtl/pc_unit.sv
// Program-counter unit for the single-cycle MIPS datapath: sequential, branch, jump,
// jump-register, exception and ERET sources, with an optional one-slot branch delay.
//   state   | meaning
//   S_NORMAL | fetching normally; transfers are accepted
//   S_DELAY  | executing the delay slot; latched target loads on the next enabled edge
module pc_unit #(
    parameter int          WIDTH        = 32,
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter logic [31:0] EXC_VECTOR   = 32'h0000_0080,
    parameter int          DELAY_SLOT   = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             zero,
    input  logic             branch,
    input  logic             branch_ne,
    input  logic             jump,
    input  logic             jump_reg,
    input  logic             exception,
    input  logic             eret,
    input  logic [WIDTH-1:0] imm,
    input  logic [25:0]      jtarget,
    input  logic [WIDTH-1:0] rs_value,
    output logic [WIDTH-1:0] pc,
    output logic [WIDTH-1:0] pc_plus4,
    output logic [WIDTH-1:0] link_addr,
    output logic [WIDTH-1:0] epc,
    output logic             in_delay_slot,
    output logic             misaligned
);

    typedef enum logic {S_NORMAL = 1'b0, S_DELAY = 1'b1} state_t;

    localparam logic [WIDTH-1:0] RST_PC = WIDTH'(RESET_VECTOR);
    localparam logic [WIDTH-1:0] EXC_PC = WIDTH'(EXC_VECTOR);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] pc_q, pc_d;
    logic [WIDTH-1:0] epc_q, epc_d;
    logic [WIDTH-1:0] tgt_q, tgt_d;
    logic             misaligned_q, misaligned_d;

    logic [WIDTH-1:0] btarget, jtgt, redirect;
    logic             taken, jr_trap, in_dly;

    assign pc_plus4 = pc_q + WIDTH'(4);
    assign btarget  = pc_plus4 + (imm << 2);

    generate
        if (WIDTH > 28) begin : g_jtgt_hi
            assign jtgt = {pc_plus4[WIDTH-1:28], jtarget, 2'b00};
        end else begin : g_jtgt_lo
            assign jtgt = {jtarget, 2'b00};
        end
    endgenerate

    assign taken    = (branch & zero) | (branch_ne & ~zero);
    assign jr_trap  = jump_reg & (rs_value[1:0] != 2'b00);
    assign redirect = jump_reg ? rs_value : (jump ? jtgt : btarget);
    assign in_dly   = (DELAY_SLOT != 0) && (state_q == S_DELAY);

    always_comb begin
        pc_d         = pc_q;
        epc_d        = epc_q;
        tgt_d        = tgt_q;
        state_d      = state_q;
        misaligned_d = misaligned_q;
        if (en) begin
            misaligned_d = 1'b0;
            if (exception) begin
                // A trap in the slot must restart at the branch, one word back.
                pc_d    = EXC_PC;
                epc_d   = in_dly ? (pc_q - WIDTH'(4)) : pc_q;
                tgt_d   = '0;
                state_d = S_NORMAL;
            end else if (eret) begin
                pc_d    = epc_q;
                tgt_d   = '0;
                state_d = S_NORMAL;
            end else if (in_dly) begin
                pc_d    = tgt_q;
                tgt_d   = '0;
                state_d = S_NORMAL;
            end else if (jr_trap) begin
                pc_d         = EXC_PC;
                epc_d        = pc_q;
                misaligned_d = 1'b1;
            end else if (jump_reg || jump || taken) begin
                if (DELAY_SLOT != 0) begin
                    tgt_d   = redirect;
                    pc_d    = pc_plus4;
                    state_d = S_DELAY;
                end else begin
                    pc_d = redirect;
                end
            end else begin
                pc_d = pc_plus4;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_q         <= RST_PC;
            epc_q        <= '0;
            tgt_q        <= '0;
            state_q      <= S_NORMAL;
            misaligned_q <= 1'b0;
        end else begin
            pc_q         <= pc_d;
            epc_q        <= epc_d;
            tgt_q        <= tgt_d;
            state_q      <= state_d;
            misaligned_q <= misaligned_d;
        end
    end

    assign pc            = pc_q;
    assign epc           = epc_q;
    assign link_addr     = (DELAY_SLOT != 0) ? (pc_q + WIDTH'(8)) : pc_plus4;
    assign in_delay_slot = in_dly;
    assign misaligned    = misaligned_q;

endmodule

// File: doc/pc_unit.md
Name: pc_unit

Overview:
- Parametrised program-counter unit for the single-cycle MIPS datapath; successor to the fixed 32-bit branch/jump PC block.
- Holds the PC register and computes the next PC from sequential, branch (BEQ/BNE), jump (J/JAL), jump-register (JR/JALR), exception and ERET sources.
- Adds a stall enable, an EPC register, a link address for JAL/JALR, misaligned-target trapping, and an optional MIPS branch-delay-slot mode driven by a two-state FSM.
- Sits between the control unit/ALU zero flag and instruction memory.

Parameters:
- WIDTH, 32, PC/data width; must be at least 28.
- RESET_VECTOR, 32'h0000_0000, PC value on reset (WIDTH bits used).
- EXC_VECTOR, 32'h0000_0080, exception handler address.
- DELAY_SLOT, 0, 1 = one architectural branch delay slot; 0 = immediate redirect.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset.
- en  input  1  advance enable; 0 = hold all state (stall).
- zero  input  1  ALU zero flag.
- branch  input  1  BEQ: taken when zero=1.
- branch_ne  input  1  BNE: taken when zero=0.
- jump  input  1  J/JAL.
- jump_reg  input  1  JR/JALR.
- exception  input  1  synchronous trap request.
- eret  input  1  return from exception.
- imm  input  WIDTH  sign-extended 16-bit immediate.
- jtarget  input  26  J-format target field.
- rs_value  input  WIDTH  register value for JR.
- pc  output  WIDTH  current PC (registered).
- pc_plus4  output  WIDTH  pc+4 (combinational).
- link_addr  output  WIDTH  pc+4 if DELAY_SLOT=0, else pc+8.
- epc  output  WIDTH  exception PC (registered).
- in_delay_slot  output  1  1 while FSM is in DELAY.
- misaligned  output  1  registered one-cycle pulse on a JR-target trap.

Behaviour:
- Reset (reset=0, async): pc=RESET_VECTOR, epc=0, state=NORMAL, misaligned=0.
- en=0: pc, epc, state and misaligned are all held. Control inputs are ignored for that cycle.
- Target arithmetic, all modulo 2^WIDTH:
  - btarget = pc_plus4 + (imm<<2).
  - jtgt = {pc_plus4[WIDTH-1:28], jtarget, 2'b00}.
  - rtgt = rs_value.
- Branch taken when (branch & zero) | (branch_ne & ~zero). Asserting both branch and branch_ne is legal: the branch is then always taken.
- Source priority, highest first: exception > eret > jump_reg > jump > taken branch > sequential (pc_plus4).
- exception (any state): pc<=EXC_VECTOR. epc<=pc in NORMAL, pc-4 in DELAY. state<=NORMAL; any pending target is discarded.
- eret: pc<=epc, state<=NORMAL.
- jump_reg with rs_value[1:0]!=0: treated as an exception (pc<=EXC_VECTOR, epc<=pc). misaligned=1 for the next cycle only.
- misaligned clears on the next enabled cycle. It is not asserted by any other source.
- DELAY_SLOT=0: the selected target loads into pc on the same edge; FSM is unused, in_delay_slot stays 0.
- DELAY_SLOT=1, FSM states NORMAL and DELAY:
  - NORMAL + jump/jump_reg/taken branch: latch the target into an internal register; pc<=pc_plus4; state<=DELAY.
  - DELAY, next enabled edge: pc<=latched target; state<=NORMAL.
  - DELAY: branch/jump/jump_reg inputs are ignored (no nested transfers). exception and eret are honoured.
  - Stall (en=0) during DELAY keeps both the state and the latched target.
- Reset mid-DELAY returns to NORMAL at RESET_VECTOR; the latched target is cleared.
- Wrap-around: pc=all-ones-minus-3 advances to 0 with no flag.

Test Plan:
- Reset then release with en=1 and no controls -> pc=0x0 during reset, then 0x4, 0x8, 0xC on successive edges.
- DELAY_SLOT=0, pc=0x4, branch=1, zero=1, imm=2 -> pc=0x10. Repeat with zero=0 -> pc=0x8. BNE with zero=0 -> 0x10.
- DELAY_SLOT=1, pc=0x4, jump=1, jtarget=0x40 -> pc=0x8 with in_delay_slot=1, then pc=0x100. Hold en=0 for 3 cycles inside DELAY -> pc stays 0x8 until en returns.
- jump_reg with rs_value=0x202 at pc=0x20 -> pc=EXC_VECTOR=0x80, epc=0x20, misaligned pulse 1 cycle. Then eret -> pc=0x20.
- DELAY_SLOT=1, exception in DELAY at pc=0x8 -> epc=0x4, pc=0x80, pending target dropped. Assert reset mid-DELAY -> pc=0x0 immediately, in_delay_slot=0.
- exception+eret+jump asserted together -> exception wins, pc=0x80. pc=0xFFFF_FFFC sequential -> pc=0x0.
